// File: rtl/core_sim_pkg.sv
// Shared encodings for the Core run controller: FSM states, run modes, halt causes.
package core_sim_pkg;

  typedef enum logic [2:0] {
    ST_RSTSEQ,
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_DUMP,
    ST_HALT
  } state_t;

  typedef enum logic [1:0] {
    MODE_FREE   = 2'd0,
    MODE_STEP   = 2'd1,
    MODE_BUDGET = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_BREAK  = 2'd1,
    CAUSE_BUDGET = 2'd2,
    CAUSE_STOP   = 2'd3
  } cause_t;

endpackage

// File: rtl/step_edge_sync.sv
// Two-flop synchroniser for the asynchronous step button, with a rising-edge strobe
// taken from the synchronised level.
module step_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  // sh[0], sh[1] form the synchroniser; sh[2] is the previous synchronised level
  logic [2:0] sh;

  always_ff @(posedge clk) begin
    if (rst) sh <= '0;
    else     sh <= {sh[1:0], din};
  end

  assign rise = sh[1] & ~sh[2];

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller for Core: reset sequencing, free-run / single-step / budget execution,
// halt detection and a post-halt register dump through Core's debug port.
//
//  state  | meaning
//  RSTSEQ | core_aresetn held low for RST_CYCLES cycles
//  IDLE   | core out of reset, waiting for start
//  RUN    | free run (FREE or BUDGET), counting cycles and retires
//  STEP   | one core_step pulse per synchronised step_req edge
//  DUMP   | scanning register file, one address per cycle
//  HALT   | dump complete, waiting for start or restart
module core_run_ctrl
  import core_sim_pkg::*;
#(
  parameter int RST_CYCLES = 2,
  parameter int XLEN       = 64,
  parameter int CNT_W      = 32,
  parameter int NUM_REGS   = 32,
  parameter int RADDR_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               restart,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   cycle_budget,
  input  logic               break_en,
  input  logic [XLEN-1:0]    break_pc,
  input  logic               step_req,
  input  logic               retire_valid,
  input  logic [XLEN-1:0]    retire_pc,
  input  logic [XLEN-1:0]    debug_reg_data,
  output logic               core_aresetn,
  output logic               core_step,
  output logic               core_debug_mode,
  output logic [RADDR_W-1:0] debug_reg_addr,
  output logic               dump_valid,
  output logic [RADDR_W-1:0] dump_idx,
  output logic [XLEN-1:0]    dump_data,
  output logic               busy,
  output logic               halted,
  output logic [1:0]         halt_cause,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   retire_count
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_INIT = RC_W'(RST_CYCLES - 1);
  localparam logic [RADDR_W-1:0] LAST_ADDR = RADDR_W'(NUM_REGS - 1);

  state_t state, state_nxt;
  mode_t run_mode;
  cause_t halt_sel;
  logic [RC_W-1:0] rst_cnt;
  logic [CNT_W-1:0] budget_rem;
  logic [XLEN-1:0] break_pc_q;
  logic step_edge, start_ok, budget_zero, active, step_fire;
  logic hit_break, hit_budget, halt_now, last_addr;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  step_edge_sync u_step_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (step_req),
    .rise (step_edge)
  );

  assign start_ok    = start & ((state == ST_IDLE) | (state == ST_HALT));
  assign budget_zero = (mode == MODE_BUDGET) & (cycle_budget == '0);
  assign active      = (state == ST_RUN) | (state == ST_STEP);
  assign step_fire   = (state == ST_STEP) & step_edge;
  assign hit_break   = retire_valid & break_en & (retire_pc == break_pc_q);
  // budget_rem is a down-counter: reaching 1 means this RUN cycle exhausts the budget
  assign hit_budget  = (state == ST_RUN) & (run_mode == MODE_BUDGET) & (budget_rem == CNT_W'(1));
  assign halt_now    = active & (hit_break | hit_budget | stop);
  assign last_addr   = (debug_reg_addr == LAST_ADDR);

  always_comb begin
    halt_sel = CAUSE_STOP;
    if (hit_break)       halt_sel = CAUSE_BREAK;
    else if (hit_budget) halt_sel = CAUSE_BUDGET;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RSTSEQ;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (restart) begin
      state_nxt = ST_RSTSEQ;
    end else begin
      case (state)
        ST_RSTSEQ: if (rst_cnt == '0) state_nxt = ST_IDLE;
        ST_IDLE, ST_HALT: begin
          if (start) begin
            if (budget_zero)             state_nxt = ST_DUMP;
            else if (mode == MODE_STEP)  state_nxt = ST_STEP;
            else                         state_nxt = ST_RUN;
          end
        end
        ST_RUN, ST_STEP: if (halt_now) state_nxt = ST_DUMP;
        ST_DUMP: if (last_addr) state_nxt = ST_HALT;
        default: state_nxt = ST_RSTSEQ;
      endcase
    end
  end

  always_comb begin
    core_aresetn    = (state != ST_RSTSEQ);
    core_debug_mode = (state == ST_RUN);
    busy            = active | (state == ST_DUMP);
    halted          = (state == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_cnt        <= RC_INIT;
      run_mode       <= MODE_FREE;
      budget_rem     <= '0;
      break_pc_q     <= '0;
      halt_cause     <= CAUSE_NONE;
      cycle_count    <= '0;
      retire_count   <= '0;
      core_step      <= 1'b0;
      debug_reg_addr <= '0;
      dump_valid     <= 1'b0;
      dump_idx       <= '0;
      dump_data      <= '0;
    end else begin
      core_step  <= step_fire & ~restart;
      dump_valid <= (state == ST_DUMP) & ~restart;
      dump_idx   <= debug_reg_addr;
      if (state == ST_DUMP) dump_data <= debug_reg_data;

      if (restart) begin
        rst_cnt        <= RC_INIT;
        halt_cause     <= CAUSE_NONE;
        cycle_count    <= '0;
        retire_count   <= '0;
        debug_reg_addr <= '0;
      end else begin
        if ((state == ST_RSTSEQ) && (rst_cnt != '0)) rst_cnt <= rst_cnt - RC_W'(1);

        if (start_ok) begin
          cycle_count  <= '0;
          retire_count <= '0;
          budget_rem   <= cycle_budget;
          break_pc_q   <= break_pc;
          run_mode     <= (mode == MODE_RSVD) ? MODE_FREE : mode_t'(mode);
          halt_cause   <= budget_zero ? CAUSE_BUDGET : CAUSE_NONE;
        end

        if (active) begin
          if ((state == ST_RUN) || step_fire) cycle_count <= sat_inc(cycle_count);
          if (retire_valid) retire_count <= sat_inc(retire_count);
          if ((state == ST_RUN) && (budget_rem != '0)) budget_rem <= budget_rem - CNT_W'(1);
          if (halt_now) halt_cause <= halt_sel;
        end

        if (state == ST_DUMP) debug_reg_addr <= last_addr ? '0 : debug_reg_addr + RADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: dump words are scoreboarded by a negedge monitor,
// sequencing and counter results are checked inline against hand-computed values.
module tb_core_run_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, restart, stop, break_en, step_req, retire_valid;
  logic [1:0]  mode;
  logic [31:0] cycle_budget;
  logic [63:0] break_pc, retire_pc, debug_reg_data;
  logic        core_aresetn, core_step, core_debug_mode, dump_valid, busy, halted;
  logic [4:0]  debug_reg_addr, dump_idx;
  logic [63:0] dump_data;
  logic [1:0]  halt_cause;
  logic [31:0] cycle_count, retire_count;

  typedef struct packed {
    logic [4:0]  idx;
    logic [63:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // Core register model: register n holds n*3
  always_comb debug_reg_data = 64'(debug_reg_addr) * 64'd3;

  core_run_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .restart         (restart),
    .stop            (stop),
    .mode            (mode),
    .cycle_budget    (cycle_budget),
    .break_en        (break_en),
    .break_pc        (break_pc),
    .step_req        (step_req),
    .retire_valid    (retire_valid),
    .retire_pc       (retire_pc),
    .debug_reg_data  (debug_reg_data),
    .core_aresetn    (core_aresetn),
    .core_step       (core_step),
    .core_debug_mode (core_debug_mode),
    .debug_reg_addr  (debug_reg_addr),
    .dump_valid      (dump_valid),
    .dump_idx        (dump_idx),
    .dump_data       (dump_data),
    .busy            (busy),
    .halted          (halted),
    .halt_cause      (halt_cause),
    .cycle_count     (cycle_count),
    .retire_count    (retire_count)
  );

  always @(negedge clk) begin
    if (dump_valid === 1'b1) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL dump_unexpected: got idx %0d data %0d, want no valid", dump_idx, dump_data);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (dump_idx !== e.idx || dump_data !== e.data) begin
          n_err++;
          $display("FAIL dump_word: got idx %0d data %0d, want idx %0d data %0d",
                   dump_idx, dump_data, e.idx, e.data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_dump(input int n);
    for (int i = 0; i < n; i++) sb_q.push_back({5'(i), 64'(i * 3)});
  endtask

  task automatic wait_halted(input string name);
    int g = 0;
    while (halted !== 1'b1 && g < 200) begin
      cyc();
      g++;
    end
    chk(name, 64'(halted), 64'd1);
  endtask

  task automatic do_start(input logic [1:0] m, input logic [31:0] bud);
    mode = m;
    cycle_budget = bud;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic chk_rst_seq(input string name);
    chk({name, "_low1"}, 64'(core_aresetn), 64'd0);
    cyc();
    chk({name, "_low2"}, 64'(core_aresetn), 64'd0);
    cyc();
    chk({name, "_high"}, 64'(core_aresetn), 64'd1);
    chk({name, "_idle"}, 64'({busy, halted}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int g;
    rst = 1'b1; start = 1'b0; restart = 1'b0; stop = 1'b0; mode = 2'd0;
    cycle_budget = '0; break_en = 1'b0; break_pc = '0; step_req = 1'b0;
    retire_valid = 1'b0; retire_pc = '0;

    // reset and core reset sequence
    repeat (3) cyc();
    chk("rst_aresetn", 64'(core_aresetn), 64'd0);
    chk("rst_flags", 64'({busy, halted, dump_valid, core_step}), 64'd0);
    rst = 1'b0;
    chk_rst_seq("por");

    // BUDGET run of 10 cycles
    do_start(2'd2, 32'd10);
    push_dump(32);
    cnt = 0;
    while (core_debug_mode === 1'b1 && cnt < 40) begin
      cnt++;
      cyc();
    end
    chk("budget_run_cycles", 64'(cnt), 64'd10);
    chk("budget_cycle_count", 64'(cycle_count), 64'd10);
    chk("budget_cause", 64'(halt_cause), 64'd2);
    chk("budget_in_dump", 64'(busy), 64'd1);
    wait_halted("budget_halted");
    chk("budget_addr_home", 64'(debug_reg_addr), 64'd0);

    // FREE with breakpoint; break and stop coincide
    break_en = 1'b1;
    break_pc = 64'h40;
    do_start(2'd0, 32'd0);
    push_dump(32);
    retire_valid = 1'b1;
    retire_pc = 64'h10;
    repeat (3) cyc();
    retire_pc = 64'h40;
    stop = 1'b1;
    cyc();
    retire_valid = 1'b0;
    stop = 1'b0;
    chk("break_cause", 64'(halt_cause), 64'd1);
    chk("break_retires", 64'(retire_count), 64'd4);
    chk("break_cycles", 64'(cycle_count), 64'd4);
    chk("break_dbg_mode", 64'(core_debug_mode), 64'd0);
    wait_halted("break_halted");
    break_en = 1'b0;

    // BUDGET with zero budget: straight to DUMP
    do_start(2'd2, 32'd0);
    push_dump(32);
    chk("zero_dbg_mode", 64'(core_debug_mode), 64'd0);
    chk("zero_cause", 64'(halt_cause), 64'd2);
    chk("zero_cycles", 64'(cycle_count), 64'd0);
    wait_halted("zero_halted");

    // step press while halted must be dropped
    step_req = 1'b1;
    repeat (4) cyc();
    step_req = 1'b0;
    repeat (4) cyc();

    // STEP mode: three presses, then stop
    do_start(2'd1, 32'd0);
    push_dump(32);
    chk("step_dbg_mode", 64'({core_debug_mode, busy}), 64'b01);
    for (int p = 0; p < 3; p++) begin
      step_req = 1'b1;
      cyc();
      cyc();
      chk("step_early", 64'(core_step), 64'd0);
      cyc();
      chk("step_pulse", 64'(core_step), 64'd1);
      cyc();
      chk("step_pulse_end", 64'(core_step), 64'd0);
      step_req = 1'b0;
      repeat (3) cyc();
    end
    chk("step_count", 64'(cycle_count), 64'd3);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("step_stop_cause", 64'(halt_cause), 64'd3);
    chk("step_stop_count", 64'(cycle_count), 64'd3);
    wait_halted("step_halted");

    // restart clears counters and cause and reruns the reset sequence
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk("restart_cause", 64'(halt_cause), 64'd0);
    chk("restart_count", 64'(cycle_count), 64'd0);
    chk_rst_seq("restart");

    // rst in the middle of a dump
    do_start(2'd2, 32'd2);
    push_dump(8);
    g = 0;
    while (!(dump_valid === 1'b1 && dump_idx == 5'd7) && g < 100) begin
      cyc();
      g++;
    end
    chk("middump_reached", 64'(dump_idx), 64'd7);
    rst = 1'b1;
    cyc();
    chk("middump_ctl", 64'({core_aresetn, core_step, core_debug_mode, busy, halted}), 64'd0);
    chk("middump_dump", 64'({dump_valid, dump_idx, debug_reg_addr}), 64'd0);
    chk("middump_data", dump_data, 64'd0);
    chk("middump_cnt", 64'({halt_cause, cycle_count, retire_count}), 64'd0);
    rst = 1'b0;
    chk_rst_seq("rerst");

    repeat (3) cyc();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
